vram_arbiter: RTL

- Shares the single-port 128 KiB video SRAM between two requesters: the scanout path, which supplies a 17-bit pixel address, and the CPU bus, which reads and writes single bytes.
- Scanout fetches are detected automatically and have priority. CPU accesses are served in the gaps, with an anti-starvation guard.
- Sits between the VGA timing/scanout block, the CPU bus interface and the external SRAM pins.

---
 rtl/vram_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port 128 KiB video SRAM between the scanout
// path and the CPU bus.
//
// Scanout fetches are triggered whenever videoAddress differs from the last
// fetched address, and they have priority over the CPU. The CPU is served in
// the gaps. After STARVE_LIMIT video grants in a row while the CPU waits, the
// CPU is forced in ahead of the next video fetch.
//
// Ports:
//   clock, reset        system clock (2x pixel clock); synchronous active-high reset
//   videoAddress        scanout byte address
//   videoData           latched pixel byte
//   videoDataReady      one-clock pulse when videoData is updated
//   cpuRequest          CPU request, held until cpuAck
//   cpuWrite            1 = write, 0 = read; sampled with cpuRequest
//   cpuAddress          CPU byte address
//   cpuWriteData        CPU write byte
//   cpuReadData         CPU read byte, valid while cpuAck = 1
//   cpuAck              one-clock completion pulse
//   memAddress          SRAM address
//   memWriteData        SRAM write data
//   memReadData         SRAM read data
//   memWriteEnable      active-high SRAM write strobe
//   memOutputEnable     active-high SRAM read enable
//
// Optional build macro VRAM_ARB_STATS_EN adds the outputs:
//   cpuStallCycles      saturating count of clocks the CPU waits
//   videoLateCount      saturating count of scanout addresses that were missed
module vram_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] videoAddress,
  output logic [7:0]        videoData,
  output logic              videoDataReady,
  input  logic              cpuRequest,
  input  logic              cpuWrite,
  input  logic [ADDR_W-1:0] cpuAddress,
  input  logic [7:0]        cpuWriteData,
  output logic [7:0]        cpuReadData,
  output logic              cpuAck,
  output logic [ADDR_W-1:0] memAddress,
  output logic [7:0]        memWriteData,
  input  logic [7:0]        memReadData,
  output logic              memWriteEnable,
  output logic              memOutputEnable
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpuStallCycles,
  output logic [15:0]       videoLateCount
`endif
);

  typedef enum logic [2:0] {IDLE, VREAD, CREAD, CWRITE, CACK} state_t;

  localparam int LAT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [LAT_W-1:0]    LAT_LAST  = LAT_W'(MEM_LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_t              state, state_nxt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic [ADDR_W-1:0]   last_video_address;

  // Pending is a level: it stays set until the current address is granted,
  // and any later change re-arms it, so only the newest address is fetched.
  logic video_pending;
  logic cpu_forced;
  logic grant_video;
  logic grant_cpu;
  logic mem_done;

  assign video_pending = (videoAddress != last_video_address);
  assign cpu_forced    = cpuRequest && (starve_cnt == STARVE_MAX);
  assign grant_video   = (state == IDLE) && video_pending && !cpu_forced;
  assign grant_cpu     = (state == IDLE) && !grant_video && cpuRequest;
  assign mem_done      = (lat_cnt == LAT_LAST);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the case infers a latch.
    state_nxt       = state;
    memOutputEnable = 1'b0;
    memWriteEnable  = 1'b0;
    cpuAck          = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_video)    state_nxt = VREAD;
        else if (grant_cpu) state_nxt = cpuWrite ? CWRITE : CREAD;
      end
      VREAD: begin
        memOutputEnable = 1'b1;
        if (mem_done) state_nxt = IDLE;
      end
      CREAD: begin
        memOutputEnable = 1'b1;
        if (mem_done) state_nxt = CACK;
      end
      CWRITE: begin
        memWriteEnable = 1'b1;
        state_nxt      = CACK;
      end
      CACK: begin
        cpuAck    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= IDLE;
      lat_cnt            <= '0;
      starve_cnt         <= '0;
      last_video_address <= '1;
      memAddress         <= '0;
      memWriteData       <= '0;
      videoData          <= '0;
      videoDataReady     <= 1'b0;
      cpuReadData        <= '0;
    end else begin
      state          <= state_nxt;
      videoDataReady <= 1'b0;

      // Counts completed read-enable clocks within one access.
      if (memOutputEnable && !mem_done) lat_cnt <= lat_cnt + 1'b1;
      else                              lat_cnt <= '0;

      if (grant_video) begin
        memAddress         <= videoAddress;
        last_video_address <= videoAddress;
        if (cpuRequest) starve_cnt <= starve_cnt + 1'b1;
      end else if (grant_cpu) begin
        memAddress   <= cpuAddress;
        memWriteData <= cpuWriteData;
        starve_cnt   <= '0;
      end

      if (state == VREAD && mem_done) begin
        videoData      <= memReadData;
        videoDataReady <= 1'b1;
      end
      if (state == CREAD && mem_done) cpuReadData <= memReadData;
    end
  end

`ifdef VRAM_ARB_STATS_EN
  logic [ADDR_W-1:0] prev_video_address;
  logic              video_changed;
  logic              video_late;
  logic              cpu_stalled;

  // A change is late when the address it replaces was still unfetched.
  assign video_changed = (videoAddress != prev_video_address);
  assign video_late    = video_changed && (prev_video_address != last_video_address);
  assign cpu_stalled   = cpuRequest && (state == IDLE || state == VREAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_video_address <= '1;
      cpuStallCycles     <= '0;
      videoLateCount     <= '0;
    end else begin
      prev_video_address <= videoAddress;
      if (cpu_stalled && cpuStallCycles != 16'hFFFF) cpuStallCycles <= cpuStallCycles + 16'd1;
      if (video_late && videoLateCount != 16'hFFFF) videoLateCount <= videoLateCount + 16'd1;
    end
  end
`endif

endmodule
